// File: rtl/dcache_dram_ctrl.sv
// 2-way set-associative write-back/write-allocate data cache with a word-addressed DRAM model.
// Optional performance counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_dram_ctrl #(
  parameter int SETS           = 1024,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS      = 1048576,
  parameter int MISS_LATENCY   = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemToRegM,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memstall
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam int MB = $clog2(MEM_WORDS);
  localparam logic [7:0] LAT = 8'(MISS_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_t;

  // Line storage and DRAM
  logic [31:0]     r_data [2][SETS][WORDS_PER_LINE];
  logic [TB-1:0]   r_tag  [2][SETS];
  logic [31:0]     r_dram [MEM_WORDS];
  logic [SETS-1:0] r_valid [2];
  logic [SETS-1:0] r_dirty [2];
  logic [SETS-1:0] r_lru;

  // Miss-sequence context
  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_way;
  logic [IB-1:0]   r_index;
  logic [TB-1:0]   r_req_tag;

  logic [OB-1:0]   w_offset;
  logic [IB-1:0]   w_index;
  logic [TB-1:0]   w_tag;
  logic            w_req;
  logic            w_hit0;
  logic            w_hit1;
  logic            w_hit;
  logic            w_hit_way;
  logic            w_victim;
  logic [7:0]      w_cnt_next;
  logic            w_done;
  logic [TB-1:0]   w_victim_tag;
  logic [1:0]      w_unused_bits;

  assign w_offset      = address[OB+1:2];
  assign w_index       = address[OB+2 +: IB];
  assign w_tag         = address[31 -: TB];
  assign w_unused_bits = address[1:0];

  assign w_req     = MemToRegM | write;
  assign w_hit0    = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
  assign w_hit1    = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
  assign w_hit     = w_req && (w_hit0 || w_hit1);
  assign w_hit_way = ~w_hit0;

  // Prefer an empty way (way 0 first) before evicting the LRU way
  assign w_victim = !r_valid[0][w_index] ? 1'b0 :
                    !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];

  assign w_cnt_next   = r_cnt + 8'd1;
  assign w_done       = (w_cnt_next == LAT);
  assign w_victim_tag = r_tag[r_way][r_index];

  function automatic logic [MB-1:0] dram_addr(input logic [TB-1:0] tag,
                                              input logic [IB-1:0] idx,
                                              input logic [OB-1:0] off);
    return MB'({tag, idx, off});
  endfunction

  always_comb begin
    read_data = '0;
    if (r_state == S_IDLE && w_hit && !write)
      read_data = r_data[w_hit_way][w_index][w_offset];
    memstall = (r_state != S_IDLE) || (w_req && !w_hit);
  end

  // NOTE: data, tag and DRAM arrays carry no reset; the valid bits alone qualify
  // their contents, and resetting large arrays would cost a clear loop in hardware.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == S_IDLE && w_hit && write)
        r_data[w_hit_way][w_index][w_offset] <= write_data;
      if (r_state == S_WRITEBACK && w_done) begin
        for (int j = 0; j < WORDS_PER_LINE; j++)
          r_dram[dram_addr(w_victim_tag, r_index, OB'(j))] <= r_data[r_way][r_index][j];
      end
      if (r_state == S_FILL && w_done) begin
        for (int j = 0; j < WORDS_PER_LINE; j++)
          r_data[r_way][r_index][j] <= r_dram[dram_addr(r_req_tag, r_index, OB'(j))];
        r_tag[r_way][r_index] <= r_req_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_way      <= 1'b0;
      r_index    <= '0;
      r_req_tag  <= '0;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
`ifdef DCACHE_PERF_CNT_EN
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_lru[w_index] <= ~w_hit_way;
            if (write) r_dirty[w_hit_way][w_index] <= 1'b1;
`ifdef DCACHE_PERF_CNT_EN
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
          end else if (w_req) begin
            r_way     <= w_victim;
            r_index   <= w_index;
            r_req_tag <= w_tag;
            r_cnt     <= '0;
            r_state   <= (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index])
                         ? S_WRITEBACK : S_FILL;
`ifdef DCACHE_PERF_CNT_EN
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        S_WRITEBACK: begin
          r_cnt <= w_cnt_next;
          if (w_done) begin
            r_cnt   <= '0;
            r_state <= S_FILL;
`ifdef DCACHE_PERF_CNT_EN
            if (wb_count != '1) wb_count <= wb_count + 32'd1;
`endif
          end
        end
        S_FILL: begin
          r_cnt <= w_cnt_next;
          if (w_done) begin
            // LRU is left alone; the replayed hit in IDLE updates it
            r_cnt                   <= '0;
            r_valid[r_way][r_index] <= 1'b1;
            r_dirty[r_way][r_index] <= 1'b0;
            r_state                 <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dram_ctrl.sv
// Scoreboard bench for dcache_dram_ctrl: the driver queues expected stall length and load
// data per request, an independent monitor pops and compares when a request completes.
module tb_dcache_dram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        MemToRegM = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        memstall;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  dcache_dram_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MemToRegM  (MemToRegM),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .memstall   (memstall)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts stalled cycles of the current request and checks it on completion
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !(MemToRegM || write)) begin
        stall_cnt = 0;
      end else if (memstall) begin
        stall_cnt++;
      end else if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_completion: got request done at addr 0x%08h, expected none", address);
        stall_cnt = 0;
      end else begin
        e = sb.pop_front();
        check({e.name, "_stall"}, 32'(stall_cnt), 32'(e.stall));
        check({e.name, "_rdata"}, read_data, e.rdata);
        stall_cnt = 0;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (entered at posedge+1, returns at posedge+1 after completion)
  task automatic req(input string name, input bit st, input bit ld, input logic [31:0] addr,
                     input logic [31:0] wd, input int exp_stall, input logic [31:0] exp_rd);
    int k;
    exp_t e;
    e.name = name;
    e.rdata = exp_rd;
    e.stall = exp_stall;
    sb.push_back(e);
    write      = st;
    MemToRegM  = ld;
    address    = addr;
    write_data = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (memstall && k < 200);
    if (memstall) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got memstall still high after %0d cycles, expected release", name, k);
      void'(sb.pop_back());
    end
    sync();
    write     = 1'b0;
    MemToRegM = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sync();
    reset_n = 1'b1;
  endtask

  task automatic load(input string name, input logic [31:0] addr, input int stall,
                      input logic [31:0] rd);
    req(name, 1'b0, 1'b1, addr, 32'h0, stall, rd);
  endtask

  task automatic store(input string name, input logic [31:0] addr, input logic [31:0] wd);
    req(name, 1'b1, 1'b0, addr, wd, 0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dut.r_dram[20'h00100] = 32'hDEADBEEF;
    dut.r_dram[20'h00101] = 32'h11110101;
    dut.r_dram[20'h04100] = 32'hA0004100;
    dut.r_dram[20'h08100] = 32'hA0008100;
    dut.r_dram[20'h00000] = 32'hB0000000;
    dut.r_dram[20'h01000] = 32'hB0001000;
    dut.r_dram[20'h02000] = 32'hB0002000;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_memstall", {31'b0, memstall}, 32'h0);
    check("reset_read_data", read_data, 32'h0);
    sync();

    // Cold load
    load("t1_cold_load", 32'h0000_0400, 21, 32'hDEADBEEF);

    // Store hit, then a dirty write-back of that line
    store("t2_store_hit", 32'h0000_0404, 32'h12345678);
    check("t2_no_write_through", dut.r_dram[20'h00101], 32'h11110101);
    load("t2_way1_fill", 32'h0001_0400, 21, 32'hA0004100);
    load("t2_dirty_evict", 32'h0002_0400, 41, 32'hA0008100);
    check("t2_wb_word1", dut.r_dram[20'h00101], 32'h12345678);
    check("t2_wb_word0", dut.r_dram[20'h00100], 32'hDEADBEEF);
`ifdef DCACHE_PERF_CNT_EN
    check("t6_hit_count", hit_count, 32'd4);
    check("t6_miss_count", miss_count, 32'd3);
    check("t6_wb_count", wb_count, 32'd1);
`endif
    load("t2_refetch_wb", 32'h0000_0404, 21, 32'h12345678);
    req("t2_store_prio", 1'b1, 1'b1, 32'h0000_0408, 32'h0BADF00D, 0, 32'h0);
    load("t2_store_visible", 32'h0000_0408, 0, 32'h0BADF00D);
    load("t2_neighbour_hit", 32'h0000_0404, 0, 32'h12345678);

    // LRU replacement and clean eviction in set 0
    do_reset();
    load("t3_fill_w0", 32'h0000_0000, 21, 32'hB0000000);
    load("t3_fill_w1", 32'h0000_4000, 21, 32'hB0001000);
    load("t3_hit_w0", 32'h0000_0000, 0, 32'hB0000000);
    load("t3_evict_lru", 32'h0000_8000, 21, 32'hB0002000);
    check("t4_clean_dram_1000", dut.r_dram[20'h01000], 32'hB0001000);
    check("t4_clean_dram_0", dut.r_dram[20'h00000], 32'hB0000000);
    load("t3_survivor_hit", 32'h0000_0000, 0, 32'hB0000000);
    load("t3_evicted_miss", 32'h0000_4000, 21, 32'hB0001000);

    // Reset in the middle of a dirty write-back
    do_reset();
    load("t5_load", 32'h0000_0400, 21, 32'hDEADBEEF);
    store("t5_store", 32'h0000_0404, 32'hCAFEF00D);
    load("t5_way1", 32'h0001_0400, 21, 32'hA0004100);
    MemToRegM = 1'b1;
    address   = 32'h0002_0400;
    repeat (11) @(posedge clk);
    #1;
    check("t5_in_writeback", {31'b0, memstall}, 32'h1);
    MemToRegM = 1'b0;
    reset_n   = 1'b0;
    sync();
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_memstall_after_reset", {31'b0, memstall}, 32'h0);
    check("t5_read_data_after_reset", read_data, 32'h0);
    check("t5_dram_untouched", dut.r_dram[20'h00101], 32'h12345678);
    sync();
    load("t5_miss_after_reset", 32'h0000_0404, 21, 32'h12345678);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_dram_ctrl.md
# dcache_dram_ctrl

Parametrised data-memory subsystem for the pipelined processor's MEM stage. It combines an N-set, 2-way set-associative, write-back, write-allocate cache with a word-addressed DRAM model. Every miss runs through an explicit miss FSM that writes back only dirty victims. The cache uses per-set LRU replacement and a programmable DRAM latency, and holds `memstall` high until the requested word is resident.

## Interface
Parameters:
- `SETS`, 1024: sets per way; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `MEM_WORDS`, 1048576: DRAM depth in words; power of two.
- `MISS_LATENCY`, 20: cycles per DRAM line transfer (write-back or fill); 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `MemToRegM`  in  1  load request.
- `write`  in  1  store request; has priority over `MemToRegM` when both are high.
- `address`  in  32  byte address; bits [1:0] ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; combinational.
- `memstall`  out  1  stall the pipeline; combinational.
- `hit_count`, `miss_count`, `wb_count`  out  32 each  performance counters (only with `DCACHE_PERF_CNT_EN`).

## Operation
Address fields:
- offset = `address[OB+1:2]`, where OB = log2(WORDS_PER_LINE).
- index = next log2(SETS) bits above the offset.
- tag = remaining upper bits: width 30 − OB − log2(SETS), which is 18 at defaults.

Storage per set:
- Per way: valid, dirty, tag, and data line.
- One LRU bit naming the least-recently-used way.

DRAM addressing:
- DRAM word address = low log2(MEM_WORDS) bits of `address[31:2]`; higher bits alias.
- Victim write-back address is rebuilt from the victim's stored tag and the index.

Hit definition:
- Hit = a request is present AND some way has valid=1 and a matching tag.

FSM states: IDLE, WRITEBACK, FILL.
- **IDLE, hit:**
  - Load: `read_data` = the addressed word.
  - Store: the word is written at the edge and that way's dirty bit is set.
  - Either way, LRU points to the other way.
- **IDLE, miss:**
  - Victim = an invalid way if one exists (way 0 first), else the LRU way.
  - If the victim is valid and dirty → WRITEBACK; otherwise → FILL.
  - The counter is cleared.
- **WRITEBACK:**
  - The counter increments each cycle.
  - At count == MISS_LATENCY, the victim line is written to DRAM in one edge → FILL, counter cleared.
- **FILL:**
  - The counter increments each cycle.
  - At count == MISS_LATENCY, the victim way is loaded with the DRAM line, valid=1, dirty=0, tag updated → IDLE.
  - LRU is not changed here; the replayed hit updates it.
- The victim way is latched on entry to the miss sequence.
- Address and request are sampled on miss detection and held internally until IDLE; changes to the inputs meanwhile are ignored.
- If the request drops mid-miss, the sequence still completes.

Outputs:
- `memstall` = (request & ~hit) in IDLE, or state ≠ IDLE.
- `read_data` = 0 unless a load hits in IDLE.

Reset (`reset_n`=0 at an edge):
- State → IDLE, counter = 0.
- All valid, dirty and LRU bits cleared.
- Counters cleared.
- DRAM contents untouched.
- A reset mid-miss abandons the sequence: no DRAM write, and dirty data is lost.
- Outputs after reset: `memstall`=0 and `read_data`=0 when no request is present.

## Timing
Hit:
- Zero added latency; `memstall` stays 0.
- Store data is visible to a load the next cycle.

Clean miss:
- `memstall` high for 1 + MISS_LATENCY cycles (21 at default), then one hit cycle.

Dirty miss:
- `memstall` high for 1 + 2·MISS_LATENCY cycles (41 at default).

DRAM ordering:
- The DRAM write of a write-back occurs strictly before the fill read of the same line.
- A miss whose victim aliases the requested DRAM line therefore reads the fresh data.

Back-to-back misses:
- The next request is evaluated in the IDLE cycle after the replayed hit.

## Configuration
`DCACHE_PERF_CNT_EN` defined:
- `hit_count` increments on each IDLE hit cycle with a request present, including the replayed hit.
- `miss_count` increments on each IDLE→WRITEBACK/FILL transition.
- `wb_count` increments on each completed write-back.
- All three saturate at 2^32−1 and clear on reset.

Undefined:
- The three ports and their counters are absent; all other behaviour is identical.

## Test plan
Defaults throughout (SETS=1024, WORDS_PER_LINE=4, MISS_LATENCY=20).

1. **Cold load.** Preload DRAM word 0x100 = 0xDEADBEEF; reset; load from address 0x400 → `memstall` high exactly 21 cycles, then `read_data`=0xDEADBEEF with `memstall`=0.
2. **Store hit, dirty write-back.**
   - Load 0x400; store 0x12345678 to 0x404 → no stall.
   - Load 0x10400 (same set, way 1), then load 0x20400 → victim is the dirty 0x400 line, `memstall` high 41 cycles, DRAM word 0x101 = 0x12345678.
3. **LRU.**
   - Fill set 0 with 0x0 and 0x4000; hit 0x0; load 0x8000 → 0x4000 is evicted.
   - Load 0x0 → hit, no stall.
4. **Clean eviction.** Evicting an unmodified line → stall 21 cycles, no DRAM write (DRAM snapshot unchanged).
5. **Reset mid-miss.** Assert `reset_n`=0 at cycle 10 of a dirty write-back → DRAM unchanged, `memstall`=0 after the reset edge, next load of the same address misses.
6. **Counters (macro on).** After scenario 2 → `hit_count`=4, `miss_count`=3, `wb_count`=1.
